// File: rtl/expr_pkg.sv
// Shared definitions for the expression recognizer/evaluator pair: state
// encoding, ASCII character constants and a digit test.
package expr_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_NUM   = 2'd1,
    ST_OP    = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/expr_eval_if.sv
// Character-stream handshake into the evaluator and its result outputs.
interface expr_eval_if #(parameter int W = 32);
  logic [7:0]   in;
  logic         en;
  logic         valid;
  logic [W-1:0] result;
  logic         err;

  modport master (output in, output en, input valid, input result, input err);
  modport slave  (input in, input en, output valid, output result, output err);
endinterface

// File: rtl/expr_char_class.sv
// Combinational byte classifier shared with the recognizer: exactly one of
// dig/plus/star/other is set; dval carries the digit value when dig=1.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output logic       dig,
  output logic       plus,
  output logic       star,
  output logic       other,
  output logic [3:0] dval
);

  logic [7:0] ch_off;

  always_comb begin
    ch_off = ch - CH_0;
    dig    = is_digit(ch);
    plus   = (ch == CH_PLUS);
    star   = (ch == CH_STAR);
    other  = !(dig || plus || star);
    dval   = dig ? ch_off[3:0] : 4'd0;
  end

endmodule

// File: rtl/expr_eval.sv
// Evaluates a '+'/'*' single-digit expression stream on the fly, '*' binding
// tighter than '+'; sum holds completed products, term the product in progress.
//
// state   | meaning
// START   | waiting for the first digit
// NUM     | last character was a digit; prefix is a legal expression
// OP      | last character was an operator; a digit must follow
// ERR     | illegal input seen; frozen until clr
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_NUM   = ST_NUM;
  localparam logic [1:0] S_OP    = ST_OP;
  localparam logic [1:0] S_ERR   = ST_ERR;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic         mul_pend_q, mul_pend_d;

  logic         cc_dig, cc_plus, cc_star, cc_other;
  logic [3:0]   cc_dval;
  logic [W-1:0] dval_w;

  expr_char_class u_cc (
    .ch    (bus.in),
    .dig   (cc_dig),
    .plus  (cc_plus),
    .star  (cc_star),
    .other (cc_other),
    .dval  (cc_dval)
  );

  assign dval_w = W'(cc_dval);

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_d     = term_q;
    mul_pend_d = mul_pend_q;
    case (state_q)
      S_START: begin
        if (bus.en) begin
          if (cc_dig) begin
            term_d  = dval_w;
            sum_d   = '0;
            state_d = S_NUM;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_NUM: begin
        if (bus.en) begin
          if (cc_plus) begin
            sum_d      = sum_q + term_q;
            mul_pend_d = 1'b0;
            state_d    = S_OP;
          end else if (cc_star) begin
            mul_pend_d = 1'b1;
            state_d    = S_OP;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_OP: begin
        if (bus.en) begin
          if (cc_dig) begin
            // W x 4 product, truncated to W bits
            term_d  = mul_pend_q ? W'(term_q * dval_w) : dval_w;
            state_d = S_NUM;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_START;
      sum_q      <= '0;
      term_q     <= '0;
      mul_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      mul_pend_q <= mul_pend_d;
    end
  end

  logic valid_w;

  always_comb begin
    valid_w    = (state_q == S_NUM);
    bus.valid  = valid_w;
    bus.result = valid_w ? (sum_q + term_q) : '0;
    bus.err    = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_expr_eval.sv
// Drives identical character streams into a 32-bit and an 8-bit evaluator and
// checks both against a string-level model of the expression grammar.
module tb_expr_eval;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] in_r = 8'h00;
  logic       en_r = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  expr_eval_if #(.W(32)) ifa ();
  expr_eval_if #(.W(8))  ifb ();

  assign ifa.in = in_r;
  assign ifa.en = en_r;
  assign ifb.in = in_r;
  assign ifb.en = en_r;

  expr_eval #(.W(32)) dut_a (.clk(clk), .clr(clr), .bus(ifa));
  expr_eval #(.W(8))  dut_b (.clk(clk), .clr(clr), .bus(ifb));

  // Model: accepted characters since last clr, plus a sticky illegal flag.
  byte unsigned q[$];
  bit           m_bad  = 1'b0;
  bit           chk_on = 1'b0;

  function automatic bit ch_is_digit(byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      q.delete();
      m_bad  = 1'b0;
      chk_on = 1'b1;
    end else if (en_r && !m_bad) begin
      // even positions must be digits, odd positions must be '+' or '*'
      if ((q.size() % 2) == 0) begin
        if (ch_is_digit(in_r)) q.push_back(in_r);
        else m_bad = 1'b1;
      end else begin
        if (in_r == 8'h2B || in_r == 8'h2A) q.push_back(in_r);
        else m_bad = 1'b1;
      end
    end
  end

  // Sum of products over the accepted string; wraps modulo 2^64, masked later.
  function automatic longint unsigned model_val();
    longint unsigned tot = 0;
    longint unsigned prod;
    prod = longint'(q[0] - 8'h30);
    for (int i = 1; i + 1 < q.size(); i += 2) begin
      if (q[i] == 8'h2A) prod = prod * longint'(q[i+1] - 8'h30);
      else begin
        tot  = tot + prod;
        prod = longint'(q[i+1] - 8'h30);
      end
    end
    return tot + prod;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit              ev;
    longint unsigned er;
    if (chk_on) begin
      ev = !m_bad && (q.size() % 2 == 1);
      er = ev ? model_val() : 64'd0;
      cmp("valid32",  {63'd0, ifa.valid}, {63'd0, ev});
      cmp("err32",    {63'd0, ifa.err},   {63'd0, m_bad});
      cmp("result32", {32'd0, ifa.result}, er & 64'hFFFF_FFFF);
      cmp("valid8",   {63'd0, ifb.valid}, {63'd0, ev});
      cmp("err8",     {63'd0, ifb.err},   {63'd0, m_bad});
      cmp("result8",  {56'd0, ifb.result}, er & 64'hFF);
    end
  end

  task automatic send(input byte unsigned c, input bit e = 1'b1, input bit r = 1'b0);
    in_r = c;
    en_r = e;
    clr  = r;
    @(posedge clk);
    @(negedge clk);
    clr  = 1'b0;
    en_r = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic lit(input string nm, input bit v, input int unsigned r32,
                     input int unsigned r8, input bit e);
    cmp({nm, ".valid"}, {63'd0, ifa.valid}, {63'd0, v});
    cmp({nm, ".r32"},   {32'd0, ifa.result}, {32'd0, r32});
    cmp({nm, ".r8"},    {56'd0, ifb.result}, {56'd0, r8[7:0]});
    cmp({nm, ".err"},   {63'd0, ifa.err},   {63'd0, e});
  endtask

  initial begin
    send(8'h00, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    lit("reset", 0, 0, 0, 0);

    send("1"); lit("p1_1", 1, 1, 1, 0);
    send("+"); lit("p1_2", 0, 0, 0, 0);
    send("2"); lit("p1_3", 1, 3, 3, 0);
    send("*"); lit("p1_4", 0, 0, 0, 0);
    send("3"); lit("p1_5", 1, 7, 7, 0);

    send(8'h00, 1'b0, 1'b1);
    send_str("2*3*4"); lit("p2_a", 1, 24, 24, 0);
    send_str("+5");    lit("p2_b", 1, 29, 29, 0);

    send(8'h00, 1'b0, 1'b1);
    send("7");
    for (int i = 0; i < 5; i++) send("x", 1'b0);
    lit("hold", 1, 7, 7, 0);

    send(8'h00, 1'b0, 1'b1);
    send_str("1++"); lit("err_a", 0, 0, 0, 1);
    send_str("345"); lit("err_b", 0, 0, 0, 1);
    send(8'h00, 1'b0, 1'b1); lit("err_clr", 0, 0, 0, 0);

    send_str("9*9*9*9"); lit("wrap_a", 1, 6561, 161, 0);
    send_str("+9");      lit("wrap_b", 1, 6570, 170, 0);

    send(8'h00, 1'b0, 1'b1);
    send_str("5*");
    send(8'h00, 1'b0, 1'b1);
    send("4"); lit("mid_clr", 1, 4, 4, 0);

    send("9", 1'b1, 1'b1); lit("clr_prio", 0, 0, 0, 0);
    send("*"); lit("first_star", 0, 0, 0, 1);

    send(8'h00, 1'b0, 1'b1);
    send_str("8*"); send("q"); lit("bad_after_op", 0, 0, 0, 1);
    send(8'h00, 1'b0, 1'b1);
    send_str("6*7+8*9+1"); lit("mix", 1, 115, 115, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
